dec_dispatch_ctrl: RTL and testbench

- In-order dispatch scheduler placed directly after the 4-way decoder.
- Each cycle it decides how many decoded slots (way 0..3) may leave the instruction buffer. The decision uses per-reservation-station credits, a ROB credit and illegal-instruction status.
- It drives the buffer pop count and the per-slot dispatch strobes.
- It holds dispatch after an illegal instruction until the retire stage flushes.

---
 rtl/ace_dispatch_pkg.sv | 16 +
 rtl/disp_credit_cnt.sv | 47 ++++
 rtl/dec_dispatch_ctrl.sv | 131 +++++++++++++
 tb/tb_dec_dispatch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_dispatch_pkg.sv
// Shared types and constants for the decode-to-dispatch scheduler.
package ace_dispatch_pkg;

  localparam int DISP_W = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RECOVER = 2'd2
  } disp_state_e;

  // Reservation-station id carried per decode way.
  localparam logic RS_ID_RS0 = 1'b0;
  localparam logic RS_ID_RS1 = 1'b1;

endpackage

// File: rtl/disp_credit_cnt.sv
// Free-entry credit counter: take/give per cycle, reload to full, saturating at full.
module disp_credit_cnt #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          reload_i,
  input  logic [2:0]    take_i,
  input  logic [2:0]    give_i,
  output logic [CW-1:0] credit_o
);

  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  logic [CW-1:0] credit_q;
  logic [CW:0]   add_w;
  logic [CW:0]   take_w;
  logic [CW:0]   sum_w;

  always_comb begin
    take_w = (CW+1)'(take_i);
    add_w  = {1'b0, credit_q} + (CW+1)'(give_i);
    sum_w  = add_w - take_w;
  end

  always_ff @(posedge clock) begin
    if (reset || reload_i) begin
      credit_q <= FULL[CW-1:0];
    end else if (sum_w > FULL) begin
      credit_q <= FULL[CW-1:0];
    end else begin
      credit_q <= sum_w[CW-1:0];
    end
  end

  // Consumers must never return more entries than they hold, nor take more than exist.
  always_ff @(posedge clock) begin
    if (!reset && !reload_i) begin
      assert (add_w >= take_w) else $error("disp_credit_cnt: credit underflow");
      assert (add_w <= FULL + take_w) else $error("disp_credit_cnt: credit overflow");
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/dec_dispatch_ctrl.sv
// In-order 4-way dispatch scheduler: prefix credit check, illegal-instruction hold, flush recovery.
module dec_dispatch_ctrl
  import ace_dispatch_pkg::*;
#(
  parameter int RS_DEPTH  = 8,
  parameter int ROB_DEPTH = 32,
  parameter int CW        = $clog2(ROB_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              retire_flush_i,
  input  logic [DISP_W-1:0] dec_vld_i,
  input  logic [DISP_W-1:0] dec_rs_id_i,
  input  logic [DISP_W-1:0] dec_illegal_i,
  input  logic [2:0]        rs0_release_i,
  input  logic [2:0]        rs1_release_i,
  input  logic [2:0]        rob_release_i,
  output logic [DISP_W-1:0] disp_vld_o,
  output logic [2:0]        disp_cnt_o,
  output logic              stall_o,
  output logic              excp_pend_o,
  output logic [CW-1:0]     rs0_credit_o,
  output logic [CW-1:0]     rs1_credit_o,
  output logic [CW-1:0]     rob_credit_o,
  output disp_state_e       dbg_state_o
);

  // Handshake: dec_vld_i[k] offers way k; disp_vld_o[k] accepts it in the same cycle.
  // Accepted ways are popped on this edge (disp_cnt_o); unaccepted ways are re-offered later.

  disp_state_e state_q, state_d;
  logic        disp_en;
  logic        blocked;
  logic        fits;
  logic        hit_illegal;
  logic [2:0]  rob_need, rs0_need, rs1_need;

  assign disp_en = (state_q == ST_RUN) && !retire_flush_i && !reset;

  // Cumulative demand including way k must not exceed the registered credit.
  always_comb begin
    disp_vld_o  = '0;
    rob_need    = '0;
    rs0_need    = '0;
    rs1_need    = '0;
    blocked     = 1'b0;
    hit_illegal = 1'b0;
    fits        = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      fits = 1'b0;
      if (disp_en && !blocked && dec_vld_i[k]) begin
        if (dec_illegal_i[k]) begin
          fits = (CW'(rob_need) < rob_credit_o);
        end else if (dec_rs_id_i[k] == RS_ID_RS0) begin
          fits = (CW'(rob_need) < rob_credit_o) && (CW'(rs0_need) < rs0_credit_o);
        end else begin
          fits = (CW'(rob_need) < rob_credit_o) && (CW'(rs1_need) < rs1_credit_o);
        end
      end
      if (fits) begin
        disp_vld_o[k] = 1'b1;
        rob_need      = rob_need + 3'd1;
        if (dec_illegal_i[k]) begin
          hit_illegal = 1'b1;
          blocked     = 1'b1;
        end else if (dec_rs_id_i[k] == RS_ID_RS0) begin
          rs0_need = rs0_need + 3'd1;
        end else begin
          rs1_need = rs1_need + 3'd1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (retire_flush_i) begin
      state_d = ST_RECOVER;
    end else begin
      case (state_q)
        ST_RUN:     if (hit_illegal) state_d = ST_HOLD;
        ST_HOLD:    state_d = ST_HOLD;
        ST_RECOVER: state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign disp_cnt_o  = rob_need;
  assign stall_o     = (state_q == ST_RUN) && !reset && (|(dec_vld_i & ~disp_vld_o));
  assign excp_pend_o = (state_q == ST_HOLD) && !reset;
  assign dbg_state_o = state_q;

  disp_credit_cnt #(.DEPTH(RS_DEPTH), .CW(CW)) u_rs0_credit (
    .clock    (clock),
    .reset    (reset),
    .reload_i (retire_flush_i),
    .take_i   (rs0_need),
    .give_i   (rs0_release_i),
    .credit_o (rs0_credit_o)
  );

  disp_credit_cnt #(.DEPTH(RS_DEPTH), .CW(CW)) u_rs1_credit (
    .clock    (clock),
    .reset    (reset),
    .reload_i (retire_flush_i),
    .take_i   (rs1_need),
    .give_i   (rs1_release_i),
    .credit_o (rs1_credit_o)
  );

  disp_credit_cnt #(.DEPTH(ROB_DEPTH), .CW(CW)) u_rob_credit (
    .clock    (clock),
    .reset    (reset),
    .reload_i (retire_flush_i),
    .take_i   (rob_need),
    .give_i   (rob_release_i),
    .credit_o (rob_credit_o)
  );

endmodule

// File: tb/tb_dec_dispatch_ctrl.sv
// Self-checking bench for dec_dispatch_ctrl: directed scenarios plus a randomized run against a prefix-search model.
module tb_dec_dispatch_ctrl;
  import ace_dispatch_pkg::*;

  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          retire_flush_i;
  logic [3:0]    dec_vld_i, dec_rs_id_i, dec_illegal_i;
  logic [2:0]    rs0_release_i, rs1_release_i, rob_release_i;
  logic [3:0]    disp_vld_o;
  logic [2:0]    disp_cnt_o;
  logic          stall_o, excp_pend_o;
  logic [CW-1:0] rs0_credit_o, rs1_credit_o, rob_credit_o;
  disp_state_e   dbg_state_o;

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  dec_dispatch_ctrl #(.RS_DEPTH(8), .ROB_DEPTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .retire_flush_i (retire_flush_i),
    .dec_vld_i      (dec_vld_i),
    .dec_rs_id_i    (dec_rs_id_i),
    .dec_illegal_i  (dec_illegal_i),
    .rs0_release_i  (rs0_release_i),
    .rs1_release_i  (rs1_release_i),
    .rob_release_i  (rob_release_i),
    .disp_vld_o     (disp_vld_o),
    .disp_cnt_o     (disp_cnt_o),
    .stall_o        (stall_o),
    .excp_pend_o    (excp_pend_o),
    .rs0_credit_o   (rs0_credit_o),
    .rs1_credit_o   (rs1_credit_o),
    .rob_credit_o   (rob_credit_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic [3:0] vld, input logic [3:0] rs, input logic [3:0] ill,
                       input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] rb,
                       input logic fl);
    dec_vld_i = vld; dec_rs_id_i = rs; dec_illegal_i = ill;
    rs0_release_i = r0; rs1_release_i = r1; rob_release_i = rb;
    retire_flush_i = fl;
  endtask

  task automatic idle();
    drive(4'b0, 4'b0, 4'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (disp_vld_o !== 4'b0000) begin failures++; $display("FAIL reset_disp: got %b want 0000", disp_vld_o); end
    checks++; if (disp_cnt_o !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", disp_cnt_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    checks++; if (excp_pend_o !== 1'b0) begin failures++; $display("FAIL reset_excp: got %b want 0", excp_pend_o); end
    tick();
    settle();
    checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'd8, 6'd8, 6'd32}) begin
      failures++; $display("FAIL reset_credits: got %0d/%0d/%0d want 8/8/32", rs0_credit_o, rs1_credit_o, rob_credit_o); end
    checks++; if (dbg_state_o !== ST_RUN) begin failures++; $display("FAIL reset_state: got %0d want RUN", dbg_state_o); end
    tick();
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_full_dispatch();
    apply_reset();
    drive(4'b1111, 4'b1010, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (disp_vld_o !== 4'b1111) begin failures++; $display("FAIL full_disp: got %b want 1111", disp_vld_o); end
    checks++; if (disp_cnt_o !== 3'd4) begin failures++; $display("FAIL full_cnt: got %0d want 4", disp_cnt_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL full_stall: got %b want 0", stall_o); end
    tick();
    idle();
    settle();
    checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'd6, 6'd6, 6'd28}) begin
      failures++; $display("FAIL full_credits: got %0d/%0d/%0d want 6/6/28", rs0_credit_o, rs1_credit_o, rob_credit_o); end
  endtask

  task automatic test_rs_limit();
    apply_reset();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    drive(4'b0111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    drive(4'b1111, 4'b1100, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (rs0_credit_o !== 6'd1) begin failures++; $display("FAIL rs_pre_credit: got %0d want 1", rs0_credit_o); end
    checks++; if (disp_vld_o !== 4'b0001) begin failures++; $display("FAIL rs_disp: got %b want 0001", disp_vld_o); end
    checks++; if (disp_cnt_o !== 3'd1) begin failures++; $display("FAIL rs_cnt: got %0d want 1", disp_cnt_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rs_stall: got %b want 1", stall_o); end
    tick();
    idle();
    settle();
    checks++; if (rs0_credit_o !== 6'd0) begin failures++; $display("FAIL rs_post_credit: got %0d want 0", rs0_credit_o); end
  endtask

  task automatic test_illegal_flush();
    apply_reset();
    drive(4'b1111, 4'b0000, 4'b0100, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (disp_vld_o !== 4'b0111) begin failures++; $display("FAIL ill_disp: got %b want 0111", disp_vld_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ill_stall: got %b want 1", stall_o); end
    tick();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (excp_pend_o !== 1'b1) begin failures++; $display("FAIL hold_excp: got %b want 1", excp_pend_o); end
    checks++; if (disp_vld_o !== 4'b0000) begin failures++; $display("FAIL hold_disp: got %b want 0000", disp_vld_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL hold_stall: got %b want 0", stall_o); end
    checks++; if ({rs0_credit_o, rob_credit_o} !== {6'd6, 6'd29}) begin
      failures++; $display("FAIL hold_credits: got rs0=%0d rob=%0d want 6/29", rs0_credit_o, rob_credit_o); end
    tick();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd3, 1'b1);
    settle();
    checks++; if (disp_vld_o !== 4'b0000) begin failures++; $display("FAIL flush_disp: got %b want 0000", disp_vld_o); end
    tick();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (dbg_state_o !== ST_RECOVER) begin failures++; $display("FAIL recover_state: got %0d want RECOVER", dbg_state_o); end
    checks++; if (disp_vld_o !== 4'b0000) begin failures++; $display("FAIL recover_disp: got %b want 0000", disp_vld_o); end
    checks++; if (excp_pend_o !== 1'b0) begin failures++; $display("FAIL recover_excp: got %b want 0", excp_pend_o); end
    checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'd8, 6'd8, 6'd32}) begin
      failures++; $display("FAIL recover_credits: got %0d/%0d/%0d want 8/8/32", rs0_credit_o, rs1_credit_o, rob_credit_o); end
    tick();
    settle();
    checks++; if (disp_vld_o !== 4'b1111) begin failures++; $display("FAIL resume_disp: got %b want 1111", disp_vld_o); end
    tick();
    idle();
  endtask

  task automatic test_release_same_cycle();
    apply_reset();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    drive(4'b0001, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd2, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (rs0_credit_o !== 6'd3) begin failures++; $display("FAIL rel_pre_credit: got %0d want 3", rs0_credit_o); end
    checks++; if (disp_vld_o !== 4'b0111) begin failures++; $display("FAIL rel_disp: got %b want 0111", disp_vld_o); end
    checks++; if (disp_cnt_o !== 3'd3) begin failures++; $display("FAIL rel_cnt: got %0d want 3", disp_cnt_o); end
    tick();
    idle();
    settle();
    checks++; if (rs0_credit_o !== 6'd2) begin failures++; $display("FAIL rel_post_credit: got %0d want 2", rs0_credit_o); end
  endtask

  task automatic test_rob_limit_gap();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(4'b1111, 4'b1010, 4'b0000, 3'd2, 3'd2, 3'd0, 1'b0);
      tick();
    end
    drive(4'b0011, 4'b0010, 4'b0000, 3'd1, 3'd1, 3'd0, 1'b0);
    tick();
    drive(4'b1111, 4'b1010, 4'b0000, 3'd0, 3'd0, 3'd2, 1'b0);
    settle();
    checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'd8, 6'd8, 6'd2}) begin
      failures++; $display("FAIL rob_pre_credits: got %0d/%0d/%0d want 8/8/2", rs0_credit_o, rs1_credit_o, rob_credit_o); end
    checks++; if (disp_vld_o !== 4'b0011) begin failures++; $display("FAIL rob_disp: got %b want 0011", disp_vld_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rob_stall: got %b want 1", stall_o); end
    tick();
    drive(4'b1011, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (disp_vld_o !== 4'b0011) begin failures++; $display("FAIL gap_disp: got %b want 0011", disp_vld_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL gap_stall: got %b want 1", stall_o); end
    tick();
    idle();
    settle();
    checks++; if (rob_credit_o !== 6'd0) begin failures++; $display("FAIL gap_rob: got %0d want 0", rob_credit_o); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b1010, 4'b0000, 3'd2, 3'd2, 3'd0, 1'b0);
      tick();
    end
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd4, 1'b0);
    tick();
    drive(4'b1111, 4'b1110, 4'b0000, 3'd0, 3'd0, 3'd4, 1'b0);
    tick();
    drive(4'b0001, 4'b0000, 4'b0001, 3'd0, 3'd0, 3'd1, 1'b0);
    tick();
    drive(4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0);
    settle();
    checks++; if (excp_pend_o !== 1'b1) begin failures++; $display("FAIL burst_hold: got %b want 1", excp_pend_o); end
    checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'd3, 6'd5, 6'd12}) begin
      failures++; $display("FAIL burst_credits: got %0d/%0d/%0d want 3/5/12", rs0_credit_o, rs1_credit_o, rob_credit_o); end
    tick();
    reset = 1'b1;
    settle();
    checks++; if ({disp_vld_o, disp_cnt_o, stall_o, excp_pend_o} !== 9'b0) begin
      failures++; $display("FAIL burst_reset_outs: got disp=%b cnt=%0d stall=%b excp=%b want all 0",
                           disp_vld_o, disp_cnt_o, stall_o, excp_pend_o); end
    tick();
    reset = 1'b0;
    settle();
    checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'd8, 6'd8, 6'd32}) begin
      failures++; $display("FAIL burst_post_credits: got %0d/%0d/%0d want 8/8/32", rs0_credit_o, rs1_credit_o, rob_credit_o); end
    checks++; if (dbg_state_o !== ST_RUN) begin failures++; $display("FAIL burst_post_state: got %0d want RUN", dbg_state_o); end
    checks++; if (disp_vld_o !== 4'b1111) begin failures++; $display("FAIL burst_post_disp: got %b want 1111", disp_vld_o); end
    tick();
    idle();
  endtask

  // Randomized run: the model finds the longest feasible in-order prefix by search.
  task automatic test_random();
    int c0, c1, cr, n, best, k0, k1, t0, t1, l0, l1, lr;
    bit m_hold, m_rec, run_mode, stop;
    logic [3:0] vld, rs, ill, e_disp;
    logic [2:0] r0, r1, rb;
    logic fl;
    logic [8:0] exp_v, got_v;
    apply_reset();
    c0 = 8; c1 = 8; cr = 32; m_hold = 0; m_rec = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      vld = 4'($urandom_range(0, 15));
      rs  = 4'($urandom_range(0, 15));
      ill = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      l0 = (8 - c0 < 4) ? 8 - c0 : 4;
      l1 = (8 - c1 < 4) ? 8 - c1 : 4;
      lr = (32 - cr < 4) ? 32 - cr : 4;
      r0 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, l0)) : 3'd0;
      r1 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, l1)) : 3'd0;
      rb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, lr)) : 3'd0;
      fl = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      drive(vld, rs, ill, r0, r1, rb, fl);

      run_mode = !m_hold && !m_rec;
      n = 0; stop = 0;
      for (int j = 0; j < 4; j++) begin
        if (!stop && vld[j]) begin n = j + 1; if (ill[j]) stop = 1; end
        else stop = 1;
      end
      best = 0; stop = 0;
      if (run_mode && !fl) begin
        for (int p = 1; p <= n; p++) begin
          k0 = 0; k1 = 0;
          for (int j = 0; j < p; j++) if (!ill[j]) begin if (rs[j]) k1++; else k0++; end
          if (!stop && p <= cr && k0 <= c0 && k1 <= c1) best = p; else stop = 1;
        end
      end
      e_disp = 4'((1 << best) - 1);
      t0 = 0; t1 = 0;
      for (int j = 0; j < best; j++) if (!ill[j]) begin if (rs[j]) t1++; else t0++; end
      exp_q.push_back({e_disp, 3'(best), run_mode && ((vld & ~e_disp) != 4'b0), m_hold});

      settle();
      exp_v = exp_q.pop_front();
      got_v = {disp_vld_o, disp_cnt_o, stall_o, excp_pend_o};
      checks++; if (got_v !== exp_v) begin failures++;
        $display("FAIL rand_outputs cyc=%0d: got disp=%b cnt=%0d stall=%b excp=%b want disp=%b cnt=%0d stall=%b excp=%b",
                 cyc, got_v[8:5], got_v[4:2], got_v[1], got_v[0], exp_v[8:5], exp_v[4:2], exp_v[1], exp_v[0]); end
      checks++; if ({rs0_credit_o, rs1_credit_o, rob_credit_o} !== {6'(c0), 6'(c1), 6'(cr)}) begin failures++;
        $display("FAIL rand_credits cyc=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                 cyc, rs0_credit_o, rs1_credit_o, rob_credit_o, c0, c1, cr); end
      tick();

      if (fl) begin
        c0 = 8; c1 = 8; cr = 32; m_hold = 0; m_rec = 1;
      end else begin
        c0 = (c0 - t0 + r0 > 8) ? 8 : c0 - t0 + r0;
        c1 = (c1 - t1 + r1 > 8) ? 8 : c1 - t1 + r1;
        cr = (cr - best + rb > 32) ? 32 : cr - best + rb;
        if (m_rec) m_rec = 0;
        else if (run_mode && best > 0 && ill[best-1]) m_hold = 1;
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_full_dispatch();
    test_rs_limit();
    test_illegal_flush();
    test_release_same_cycle();
    test_rob_limit_gap();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
